image_streamer: RTL and testbench

IMAGE_STREAMER -- requirements
Module: image_streamer

---
 rtl/image_pkg.sv | 39 +++
 rtl/image_streamer_pixel_buffer.sv | 31 +++
 rtl/image_streamer.sv | 230 +++++++++++++++++++++++
 tb/tb_image_streamer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared definitions for the image streamer.
//   - default image geometry and on-screen placement
//   - FSM state encoding
//   - 30-bit pixel beat layout {luma, X, Y}
//   - byte-lane selector used to pick one pixel out of a packed word
package image_pkg;

    localparam int IMG_W_DEF  = 224;
    localparam int IMG_H_DEF  = 224;
    localparam int X0_DEF     = 208;
    localparam int Y0_DEF     = 128;
    localparam int IMG_PIXELS = IMG_W_DEF * IMG_H_DEF;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        STREAM,
        DONE
    } stream_state_t;

    typedef struct packed {
        logic [7:0]  luma;
        logic [10:0] x;
        logic [10:0] y;
    } pix_beat_t;

    // Byte 0 of a word holds the lowest pixel index.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/image_streamer_pixel_buffer.sv
// pixel_buffer: simple dual-port word store for packed luma.
//   clk      : clock
//   i_we     : write enable, i_waddr / i_wdata : write port
//   i_re     : read enable,  i_raddr            : read address
//   o_rdata  : registered read data (1-cycle latency, held while i_re is low)
// Contents are not reset.
module pixel_buffer #(
    parameter int DEPTH = 12544,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/image_streamer.sv
// image_streamer: Avalon-MM loaded luma buffer streamed out as pixel beats.
//   clk, reset_n        : clock, asynchronous active-low reset
//   addr/rd_en/wr_en    : register access (0 data/wptr, 1 command/status, 2 beat count, 3 zero)
//   readdata/writedata  : register data; readdata is combinational and 0 when rd_en is low
//   out_data/out_valid/out_ready : ready/valid beat stream {luma, X, Y}
// Optional feature macro: IMAGE_STREAMER_TEST_PATTERN_EN (command bit2 selects
// a generated (x + y) ramp instead of buffer contents).
module image_streamer
    import image_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int X0    = X0_DEF,
    parameter int Y0    = Y0_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  addr,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic [31:0] readdata,
    input  logic [31:0] writedata,
    output logic [29:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PIXELS = IMG_W * IMG_H;
    localparam int WORDS  = PIXELS / 4;
    localparam int WP_W   = $clog2(WORDS + 1);
    localparam int AW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W  = $clog2(PIXELS + 1);

    localparam logic [WP_W-1:0]  WP_FULL  = WP_W'(WORDS);
    localparam logic [CNT_W-1:0] PIX_END  = CNT_W'(PIXELS);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXELS - 1);
    localparam logic [10:0]      X_LAST   = 11'(IMG_W - 1);

    stream_state_t    r_state, w_state_next;
    logic [WP_W-1:0]  r_wptr, r_fetch;
    logic [CNT_W-1:0] r_nidx, r_beats;
    logic [10:0]      r_nx, r_ny;
    logic [31:0]      r_cur;
    pix_beat_t        r_beat, w_beat;
    logic             r_out_valid, r_out_last, r_done, r_err;

    logic             w_busy, w_cmd, w_start, w_clr_wptr;
    logic             w_data_wr, w_data_ok;
    logic             w_xfer, w_last_xfer, w_load, w_all_loaded;
    logic             w_re;
    logic [AW-1:0]    w_raddr;
    logic [31:0]      w_rdata, w_word;
    logic [10:0]      w_tp_sum;
    logic             w_tp_sel;

    assign w_busy       = (r_state == PREFETCH) || (r_state == STREAM);
    assign w_cmd        = wr_en && (addr == 2'd1);
    assign w_start      = w_cmd && writedata[0] && !w_busy;
    assign w_clr_wptr   = w_cmd && writedata[1] && !w_busy;
    assign w_data_wr    = wr_en && (addr == 2'd0);
    assign w_data_ok    = w_data_wr && !w_busy && (r_wptr != WP_FULL);

    assign w_xfer       = r_out_valid && out_ready;
    assign w_last_xfer  = w_xfer && r_out_last;
    assign w_all_loaded = (r_nidx == PIX_END);
    // The output register refills whenever it is empty or being drained, so
    // with out_ready held high one beat leaves per cycle.
    assign w_load       = (r_state == STREAM) && !w_all_loaded && (!r_out_valid || out_ready);

    // Pixel 4k comes from the prefetched word sitting on the buffer output;
    // the other three lanes come from the copy kept in r_cur.
    assign w_word   = (r_nidx[1:0] == 2'd0) ? w_rdata : r_cur;
    assign w_tp_sum = r_nx + r_ny;

    always_comb begin
        w_beat      = '0;
        w_beat.luma = w_tp_sel ? w_tp_sum[7:0] : word_byte(w_word, r_nidx[1:0]);
        w_beat.x    = 11'(X0) + r_nx;
        w_beat.y    = 11'(Y0) + r_ny;
    end

    assign out_data  = r_beat;
    assign out_valid = r_out_valid;

`ifdef IMAGE_STREAMER_TEST_PATTERN_EN
    logic r_tp_sel;

    // Only latched while idle so a stream in flight keeps its source.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tp_sel <= 1'b0;
        end else if (w_cmd && !w_busy) begin
            r_tp_sel <= writedata[2];
        end
    end

    assign w_tp_sel = r_tp_sel;
`else
    assign w_tp_sel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (w_start) w_state_next = PREFETCH;
            PREFETCH:   w_state_next = STREAM;
            STREAM:     if (w_last_xfer) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    // Buffer read: word 0 in PREFETCH, then the next word each time lane 0
    // consumes the prefetched one.
    always_comb begin
        w_re    = 1'b0;
        w_raddr = '0;
        if (r_state == PREFETCH) begin
            w_re = 1'b1;
        end else if (w_load && (r_nidx[1:0] == 2'd0) && (r_fetch != WP_FULL)) begin
            w_re    = 1'b1;
            w_raddr = r_fetch[AW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_fetch     <= '0;
            r_nidx      <= '0;
            r_beats     <= '0;
            r_nx        <= '0;
            r_ny        <= '0;
            r_cur       <= '0;
            r_beat      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_clr_wptr) begin
                r_wptr <= '0;
            end else if (w_data_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end

            if (w_data_wr && !w_data_ok) begin
                r_err <= 1'b1;
            end else if (w_cmd && writedata[3]) begin
                r_err <= 1'b0;
            end

            if (w_start) begin
                r_done     <= 1'b0;
                r_beats    <= '0;
                r_nidx     <= '0;
                r_nx       <= '0;
                r_ny       <= '0;
                r_out_last <= 1'b0;
            end

            if (r_state == PREFETCH) begin
                r_fetch <= WP_W'(1);
            end

            if (w_xfer) begin
                r_beats <= r_beats + 1'b1;
            end
            if (w_last_xfer) begin
                r_done <= 1'b1;
            end

            if (w_load) begin
                r_beat      <= w_beat;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_nidx == PIX_LAST);
                r_nidx      <= r_nidx + 1'b1;
                if (r_nx == X_LAST) begin
                    r_nx <= '0;
                    r_ny <= r_ny + 1'b1;
                end else begin
                    r_nx <= r_nx + 1'b1;
                end
                if (r_nidx[1:0] == 2'd0) begin
                    r_cur <= w_rdata;
                    if (r_fetch != WP_FULL) begin
                        r_fetch <= r_fetch + 1'b1;
                    end
                end
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (rd_en) begin
            case (addr)
                2'd0:    readdata = 32'({r_wptr, 2'b00});
                2'd1:    readdata = {28'd0, r_err, r_done, w_busy, w_tp_sel};
                2'd2:    readdata = 32'(r_beats);
                default: readdata = '0;
            endcase
        end
    end

    pixel_buffer #(
        .DEPTH (WORDS),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_data_ok),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (writedata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer on an 8x4 image placed at (208,128).
// Define IMAGE_STREAMER_TEST_PATTERN_EN on both bench and RTL to cover the
// generated-ramp source.
module tb_image_streamer;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int PIX = W * H;
`ifdef IMAGE_STREAMER_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] readdata;
    logic [31:0] writedata = '0;
    logic [29:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [7:0]  exp_mem [PIX];
    logic [31:0] rd;
    logic [29:0] first_beat, last_beat;
    int          nb;

    always #5 clk = ~clk;

    image_streamer #(
        .IMG_W (W),
        .IMG_H (H),
        .X0    (208),
        .Y0    (128)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .readdata  (readdata),
        .writedata (writedata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; writedata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        #1;
        d = readdata;
        rd_en = 1'b0;
    endtask

    function automatic logic [7:0] pat_byte(input int mode, input int p);
        case (mode)
            0:       return 8'(p);
            1:       return 8'(p * 3);
            default: return 8'(8'hA0 + p);
        endcase
    endfunction

    // Writes n words; pixels landing inside the image update the model.
    task automatic load(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            bus_write(2'd0, {pat_byte(mode, 4*i+3), pat_byte(mode, 4*i+2),
                             pat_byte(mode, 4*i+1), pat_byte(mode, 4*i)});
            if (i < PIX / 4) begin
                for (int b = 0; b < 4; b++) exp_mem[4*i+b] = pat_byte(mode, 4*i+b);
            end
        end
    endtask

    function automatic logic [29:0] exp_beat(input int k, input bit tp);
        logic [7:0] l;
        l = tp ? 8'((k % W) + (k / W)) : exp_mem[k];
        return {l, 11'(208 + k % W), 11'(128 + k / W)};
    endfunction

    // Consumes one stream. rnd toggles out_ready randomly; inject_at issues a
    // start+clear command then an addr0 write once that many beats are taken;
    // reset_at pulls reset_n low once that many beats are taken.
    task automatic run_stream(input bit tp, input bit rnd, input int inject_at,
                              input int reset_at, output int nbeats);
        int k = 0;
        int cyc = 0;
        int inj = 0;
        bit seen = 1'b0;
        bit prev_stall = 1'b0;
        logic [29:0] prev_data = '0;
        logic [31:0] r;
        while (k < PIX && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (inj == 1) begin
                addr = 2'd0; writedata = 32'hDEAD_BEEF; inj = 2;
            end else if (inj == 2) begin
                wr_en = 1'b0; inj = 3;
            end
            if (reset_at >= 0 && k == reset_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_valid", 32'(out_valid), 32'd0);
                check("rst_data", 32'(out_data), 32'd0);
                bus_read(2'd1, r); check("rst_status", r, 32'd0);
                bus_read(2'd2, r); check("rst_count", r, 32'd0);
                bus_read(2'd0, r); check("rst_wptr", r, 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("post_rst_quiet", 32'(out_valid), 32'd0);
                end
                nbeats = k;
                return;
            end
            if (out_valid && !seen) begin
                seen = 1'b1;
                check("first_latency", 32'(cyc <= 4), 32'd1);
            end
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (!rnd && k > 0) check("no_bubble", 32'(out_valid), 32'd1);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                check($sformatf("beat%0d", k), 32'(out_data), 32'(exp_beat(k, tp)));
                if (tp && k == 26) check("tp_x210_y131", 32'(out_data), {2'b0, 8'd5, 11'd210, 11'd131});
                if (k == 0) first_beat = out_data;
                last_beat = out_data;
                k++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (inject_at >= 0 && k == inject_at && inj == 0) begin
                addr = 2'd1; writedata = 32'h3; wr_en = 1'b1; inj = 1;
            end
        end
        wr_en = 1'b0;
        if (k < PIX) check("stream_timeout", 32'(k), 32'(PIX));
        @(negedge clk);
        check("valid_drops", 32'(out_valid), 32'd0);
        nbeats = k;
    endtask

    initial begin
        for (int p = 0; p < PIX; p++) exp_mem[p] = '0;

        // Reset state
        #12;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        bus_read(2'd0, rd); check("reset_wptr", rd, 32'd0);
        bus_read(2'd1, rd); check("reset_status", rd, 32'd0);
        bus_read(2'd2, rd); check("reset_count", rd, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full load, streamed with out_ready held high
        load(8, 0);
        bus_read(2'd0, rd); check("wptr_full", rd, 32'd32);
        bus_write(2'd1, 32'h1);
        run_stream(1'b0, 1'b0, -1, -1, nb);
        check("first_beat", 32'(first_beat), {2'b0, 8'h00, 11'd208, 11'd128});
        check("last_beat", 32'(last_beat), {2'b0, 8'h1F, 11'd215, 11'd131});
        bus_read(2'd1, rd); check("status_done", rd, 32'h4);
        bus_read(2'd2, rd); check("count_done", rd, 32'd32);
        bus_read(2'd3, rd); check("addr3_zero", rd, 32'd0);
        addr = 2'd2; rd_en = 1'b0; #1;
        check("rd_en_low_zero", readdata, 32'd0);

        // Restart from DONE with random backpressure
        bus_write(2'd1, 32'h1);
        run_stream(1'b0, 1'b1, -1, -1, nb);
        bus_read(2'd2, rd); check("count_random", rd, 32'd32);

        // Overflow: ninth word discarded and flagged
        bus_write(2'd1, 32'h2);
        load(9, 0);
        bus_read(2'd0, rd); check("wptr_overflow", rd, 32'd32);
        bus_read(2'd1, rd); check("status_err", rd, 32'hC);
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, rd); check("status_err_clr", rd, 32'h4);

        // Partial load streams stale words; start/clear/write while busy
        bus_write(2'd1, 32'h2);
        load(2, 2);
        bus_write(2'd1, 32'h1);
        run_stream(1'b0, 1'b0, 5, -1, nb);
        bus_read(2'd0, rd); check("wptr_kept_busy", rd, 32'd8);
        bus_read(2'd1, rd); check("status_busy_err", rd, 32'hC);
        bus_read(2'd2, rd); check("count_busy", rd, 32'd32);
        bus_write(2'd1, 32'h8);

        // Clear+start together, then reset mid-stream
        out_ready = 1'b0;
        bus_write(2'd1, 32'h3);
        bus_read(2'd0, rd); check("clr_start_wptr", rd, 32'd0);
        bus_read(2'd1, rd); check("clr_start_busy", rd, 32'h2);
        run_stream(1'b0, 1'b0, -1, 10, nb);
        check("rst_beats", 32'(nb), 32'd10);

        // Reload and stream; command 0x5 selects the ramp only when the feature is built
        load(8, 1);
        bus_write(2'd1, 32'h5);
        run_stream(TP, 1'b0, -1, -1, nb);
        bus_read(2'd1, rd); check("status_tp", rd, 32'h4 | 32'(TP));
        bus_read(2'd2, rd); check("count_final", rd, 32'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
